seg_scan_ctrl: RTL



---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_tick_gen.sv | 29 ++
 rtl/seg_scan_ctrl.sv | 68 ++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment display path.
// The downstream nibble mux uses the same constants.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Digit k (k >= 1) is dark when blanking is on and every nibble from k upward is zero.
  function automatic logic digit_blank(input logic [NUM_DIGITS*DIGIT_W-1:0] word,
                                       input digit_idx_t k,
                                       input logic blank_lz);
    logic blank;
    blank = blank_lz && (k != digit_idx_t'(0));
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= 32'(k)) && (word[i*DIGIT_W +: DIGIT_W] != '0)) begin
        blank = 1'b0;
      end
    end
    return blank;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Digit-slot prescaler: one-cycle tick every CLK_DIV enabled cycles.
// The counter is parked at zero while disabled so each resumed slot is full length.
module seg_tick_gen #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Refresh/scan controller for the 4-digit multiplexed display: digit select,
// active-low anodes and a double-buffered display word that only swaps at a frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blank_lz,
  output logic [15:0] seg_in,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic        pending
);

  logic        tick;
  logic        boundary;
  logic        lit_next;
  digit_idx_t  sel_next;
  logic [15:0] shadow;

  seg_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign sel_next = tick ? digit_idx_t'(sel + 2'd1) : sel;
  assign boundary = tick && (sel == digit_idx_t'(NUM_DIGITS - 1));

  // Blanking looks at the current seg_in; when seg_in swaps, sel_next is 0, which is never blanked.
  assign lit_next = enable && !digit_blank(seg_in, sel_next, blank_lz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= '0;
      seg_in  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      an      <= AN_OFF;
    end else begin
      sel <= sel_next;
      if (load) begin
        shadow <= data_in;
      end
      // A load landing on the boundary bypasses the shadow and never raises pending.
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          seg_in <= data_in;
        end else if (pending) begin
          seg_in <= shadow;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
      an <= lit_next ? ~(4'b0001 << sel_next) : AN_OFF;
    end
  end

endmodule
